// File: rtl/aont_pkg.sv
// aont_pkg: shared sizes, FSM state type and the group multiply
// used by the sequential all-or-nothing transform engine.
package aont_pkg;

  localparam int W_DEF       = 4;
  localparam int BLKSYMS_DEF = 16;
  localparam int NBLK_DEF    = 8;

  localparam int Q       = 1 << W_DEF;
  localparam int MSG_I_W = NBLK_DEF * BLKSYMS_DEF * W_DEF;
  localparam int MSG_O_W = (NBLK_DEF + 1) * BLKSYMS_DEF * W_DEF;
  localparam int KEY_W   = BLKSYMS_DEF * W_DEF;

  typedef logic [W_DEF-1:0] sym_t;

  typedef enum logic [2:0] {
    IDLE,
    LEADER,
    BODY,
    TAG,
    OUT
  } state_t;

  // Q+1 is prime for every legal W, so the residue is never 0
  // and the result always lands in [0, Q-1].
  function automatic logic [7:0] gmul(
    input logic [7:0]  x,
    input logic [7:0]  y,
    input int unsigned w
  );
    logic [17:0] m;
    logic [17:0] p;
    m = 18'((32'd1 << w) + 32'd1);
    p = (18'(x) + 18'd1) * (18'(y) + 18'd1);
    p = p % m;
    return 8'(p - 18'd1);
  endfunction

endpackage

// File: rtl/aont_ls_table.sv
// aont_ls_table: Q*Q x W Latin-square register file, async reset,
// one write port and two combinational read ports.
module aont_ls_table
  import aont_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic [2*W-1:0] waddr,
  input  logic [W-1:0]   wdata,
  input  logic [2*W-1:0] raddr_a,
  output logic [W-1:0]   rdata_a,
  input  logic [2*W-1:0] raddr_b,
  output logic [W-1:0]   rdata_b
);

  localparam int N = 1 << (2 * W);

  logic [W-1:0] mem_q [N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        mem_q[k] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/aont_seq.sv
// aont_seq: sequential all-or-nothing transform, one symbol step per cycle.
// Optional seed output port leader_o enabled by AONT_LEADER_OUT_EN.
module aont_seq
  import aont_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int BLKSYMS = BLKSYMS_DEF,
  parameter int NBLK    = NBLK_DEF
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          ls_we,
  input  logic [2*W-1:0]                ls_addr,
  input  logic [W-1:0]                  ls_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NBLK*BLKSYMS*W-1:0]     msg_i,
  input  logic [BLKSYMS*W-1:0]          key_i,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [(NBLK+1)*BLKSYMS*W-1:0] msg_o
`ifdef AONT_LEADER_OUT_EN
  ,
  output logic [W-1:0]                  leader_o
`endif
);

  localparam int JW = (BLKSYMS > 1) ? $clog2(BLKSYMS) : 1;
  localparam int IW = (NBLK > 1) ? $clog2(NBLK) : 1;

  state_t state_q, state_d;

  logic [JW-1:0] j_q, j_d;
  logic [IW-1:0] i_q, i_d;
  logic [W-1:0]  ld_q, ld_d;
  logic [W-1:0]  e_q, e_d;

  // message slots are overwritten in place by the transformed symbols
  logic [NBLK*BLKSYMS*W-1:0] msg_q, msg_d;
  logic [BLKSYMS*W-1:0]      key_q, key_d;
  logic [BLKSYMS*W-1:0]      acc_q, acc_d;

`ifdef AONT_LEADER_OUT_EN
  logic [W-1:0] leader_q, leader_d;
`endif

  logic [W-1:0] ra_row, ra_col;
  logic [W-1:0] ra_data, rb_data;
  logic [W-1:0] key_j, msg_ij, acc_j;
  logic         last_j, last_i;
  int           sidx;

  function automatic logic [W-1:0] gm(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    return W'(gmul(8'(a), 8'(b), W));
  endfunction

  aont_ls_table #(
    .W(W)
  ) u_tbl (
    .clk    (clk),
    .rst    (rstn),
    .we     (ls_we && (state_q == IDLE)),
    .waddr  (ls_addr),
    .wdata  (ls_data),
    .raddr_a({ra_row, ra_col}),
    .rdata_a(ra_data),
    .raddr_b({ra_data, msg_ij}),
    .rdata_b(rb_data)
  );

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    i_d     = i_q;
    ld_d    = ld_q;
    e_d     = e_q;
    msg_d   = msg_q;
    key_d   = key_q;
    acc_d   = acc_q;
`ifdef AONT_LEADER_OUT_EN
    leader_d = leader_q;
`endif
    ra_row = '0;
    ra_col = '0;
    sidx   = int'(i_q) * BLKSYMS + int'(j_q);
    key_j  = key_q[int'(j_q)*W +: W];
    acc_j  = acc_q[int'(j_q)*W +: W];
    msg_ij = msg_q[sidx*W +: W];
    last_j = (j_q == JW'(BLKSYMS - 1));
    last_i = (i_q == IW'(NBLK - 1));

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          msg_d   = msg_i;
          key_d   = key_i;
          ld_d    = key_i[W-1:0];
          i_d     = '0;
          j_d     = (BLKSYMS > 1) ? JW'(1) : '0;
          state_d = (BLKSYMS > 1) ? LEADER : BODY;
`ifdef AONT_LEADER_OUT_EN
          if (BLKSYMS == 1) leader_d = key_i[W-1:0];
`endif
        end
      end
      LEADER: begin
        ra_row = key_j;
        ra_col = ld_q;
        ld_d   = ra_data;
        if (last_j) begin
          j_d     = '0;
          state_d = BODY;
`ifdef AONT_LEADER_OUT_EN
          leader_d = ra_data;
`endif
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      BODY: begin
        // e chain restarts from the seed at every block
        if (j_q == '0) begin
          ra_row = ld_q;
          ra_col = '0;
        end else begin
          ra_row = e_q;
          ra_col = W'(i_q);
        end
        e_d = ra_data;
        msg_d[sidx*W +: W] = rb_data;
        acc_d[int'(j_q)*W +: W] =
          (i_q == '0) ? rb_data : gm(acc_j, rb_data);
        if (last_j) begin
          j_d = '0;
          if (last_i) begin
            i_d     = '0;
            state_d = TAG;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      TAG: begin
        acc_d[int'(j_q)*W +: W] = gm(acc_j, key_j);
        if (last_j) begin
          j_d     = '0;
          state_d = OUT;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q <= IDLE;
      j_q     <= '0;
      i_q     <= '0;
      ld_q    <= '0;
      e_q     <= '0;
      msg_q   <= '0;
      key_q   <= '0;
      acc_q   <= '0;
`ifdef AONT_LEADER_OUT_EN
      leader_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      i_q     <= i_d;
      ld_q    <= ld_d;
      e_q     <= e_d;
      msg_q   <= msg_d;
      key_q   <= key_d;
      acc_q   <= acc_d;
`ifdef AONT_LEADER_OUT_EN
      leader_q <= leader_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  // the tag lives in acc after TAG; nothing partial leaves the block
  assign msg_o     = out_valid ? {acc_q, msg_q} : '0;

`ifdef AONT_LEADER_OUT_EN
  assign leader_o = leader_q;
`endif

endmodule

// File: tb/tb_aont_seq.sv
// tb_aont_seq: scoreboard bench for aont_seq at default sizes
// and at W=8, NBLK=2, BLKSYMS=4.
module tb_aont_seq;
  import aont_pkg::*;

  localparam int W0 = 4, B0 = 16, N0 = 8;
  localparam int W1 = 8, B1 = 4, N1 = 2;
  localparam int MI0 = N0*B0*W0, MO0 = (N0+1)*B0*W0, K0 = B0*W0;
  localparam int MI1 = N1*B1*W1, MO1 = (N1+1)*B1*W1, K1 = B1*W1;

  typedef logic [1023:0] vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  logic           we0 = 0, iv0 = 0, or0 = 0, ir0, ov0;
  logic [7:0]     addr0 = '0;
  logic [3:0]     data0 = '0;
  logic [MI0-1:0] mi0 = '0;
  logic [K0-1:0]  ki0 = '0;
  logic [MO0-1:0] mo0;
  logic [3:0]     lo0;

  logic           we1 = 0, iv1 = 0, or1 = 0, ir1, ov1;
  logic [15:0]    addr1 = '0;
  logic [7:0]     data1 = '0;
  logic [MI1-1:0] mi1 = '0;
  logic [K1-1:0]  ki1 = '0;
  logic [MO1-1:0] mo1;
  logic [7:0]     lo1;

  aont_seq #(.W(W0), .BLKSYMS(B0), .NBLK(N0)) u_dut0 (
    .clk(clk), .rstn(rstn),
    .ls_we(we0), .ls_addr(addr0), .ls_data(data0),
    .in_valid(iv0), .in_ready(ir0), .msg_i(mi0), .key_i(ki0),
    .out_valid(ov0), .out_ready(or0), .msg_o(mo0)
`ifdef AONT_LEADER_OUT_EN
    , .leader_o(lo0)
`endif
  );

  aont_seq #(.W(W1), .BLKSYMS(B1), .NBLK(N1)) u_dut1 (
    .clk(clk), .rstn(rstn),
    .ls_we(we1), .ls_addr(addr1), .ls_data(data1),
    .in_valid(iv1), .in_ready(ir1), .msg_i(mi1), .key_i(ki1),
    .out_valid(ov1), .out_ready(or1), .msg_o(mo1)
`ifdef AONT_LEADER_OUT_EN
    , .leader_o(lo1)
`endif
  );

`ifndef AONT_LEADER_OUT_EN
  assign lo0 = '0;
  assign lo1 = '0;
`endif

  int n_chk = 0;
  int n_pass = 0;
  byte unsigned tbl0 [256];
  byte unsigned tbl1 [65536];
  vec_t sb0 [$];
  vec_t sb1 [$];
  int seed0;

  task automatic chk(string tag, vec_t got, vec_t exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic int sym(vec_t v, int idx, int w);
    vec_t mask;
    mask = (vec_t'(1) << w) - vec_t'(1);
    return int'((v >> (idx * w)) & mask);
  endfunction

  function automatic int lk(bit sel, int a, int b, int q);
    return sel ? int'(tbl1[a*q+b]) : int'(tbl0[a*q+b]);
  endfunction

  function automatic int gref(int x, int y, int q);
    return ((x + 1) * (y + 1)) % (q + 1) - 1;
  endfunction

  function automatic vec_t model(bit sel, int w, int bs, int nb,
                                 vec_t m, vec_t k, output int seed);
    int q, ld, e, b;
    int acc [64];
    vec_t r;
    q = 1 << w;
    r = '0;
    e = 0;
    ld = sym(k, 0, w);
    for (int j = 1; j < bs; j++) ld = lk(sel, sym(k, j, w), ld, q);
    seed = ld;
    for (int i = 0; i < nb; i++) begin
      for (int j = 0; j < bs; j++) begin
        e = (j == 0) ? lk(sel, ld, 0, q) : lk(sel, e, i % q, q);
        b = lk(sel, e, sym(m, i*bs + j, w), q);
        r |= vec_t'(b) << ((i*bs + j) * w);
        acc[j] = (i == 0) ? b : gref(acc[j], b, q);
      end
    end
    for (int j = 0; j < bs; j++)
      r |= vec_t'(gref(acc[j], sym(k, j, w), q)) << ((nb*bs + j) * w);
    return r;
  endfunction

  function automatic vec_t rnd();
    vec_t v;
    for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b1;
    foreach (tbl0[i]) tbl0[i] = 0;
    foreach (tbl1[i]) tbl1[i] = 0;
    sb0.delete();
    sb1.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
  endtask

  task automatic load0(int a, int b, int d);
    @(negedge clk);
    we0 = 1; addr0 = 8'(a*16 + b); data0 = 4'(d);
    tbl0[a*16 + b] = 8'(d);
    @(posedge clk);
    #1 we0 = 0;
  endtask

  task automatic load1(int a, int b, int d);
    @(negedge clk);
    we1 = 1; addr1 = 16'(a*256 + b); data1 = 8'(d);
    tbl1[a*256 + b] = 8'(d);
    @(posedge clk);
    #1 we1 = 0;
  endtask

  // accept on dut0 and wait for out_valid; tw adds a write on the accept edge
  task automatic run0(vec_t m, vec_t k, bit tw);
    int n;
    @(negedge clk);
    chk("ir0_idle", ir0, 1);
    mi0 = m[MI0-1:0];
    ki0 = k[K0-1:0];
    iv0 = 1;
    if (tw) begin
      we0 = 1; addr0 = 8'h00; data0 = 4'h7;
      tbl0[0] = 8'h7;
    end
    sb0.push_back(model(0, W0, B0, N0, m, k, seed0));
    @(posedge clk);
    #1 iv0 = 0; we0 = 0;
    n = 0;
    while (!ov0 && n < 1000) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk("lat0", n, 159);
  endtask

  task automatic fin0(int hold);
    vec_t snap;
    snap = mo0;
`ifdef AONT_LEADER_OUT_EN
    chk("leader0", lo0, seed0);
`endif
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      we0 = 1; addr0 = 8'(h); data0 = 4'(h ^ 5);
      @(posedge clk);
      #1;
      chk("hold_msg", mo0, snap);
      chk("hold_ir", ir0, 0);
      chk("hold_ov", ov0, 1);
    end
    @(negedge clk);
    we0 = 0;
    or0 = 1;
    chk("sb0_depth", sb0.size(), 1);
    if (sb0.size() > 0) chk("sb0_msg", mo0, sb0.pop_front());
    @(posedge clk);
    #1 or0 = 0;
    chk("ir0_after", ir0, 1);
    chk("ov0_after", ov0, 0);
  endtask

  task automatic run1(vec_t m, vec_t k);
    int n, sd;
    @(negedge clk);
    chk("ir1_idle", ir1, 1);
    mi1 = m[MI1-1:0];
    ki1 = k[K1-1:0];
    iv1 = 1;
    sb1.push_back(model(1, W1, B1, N1, m, k, sd));
    @(posedge clk);
    #1 iv1 = 0;
    n = 0;
    while (!ov1 && n < 200) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk("lat1", n, 15);
`ifdef AONT_LEADER_OUT_EN
    chk("leader1", lo1, sd);
`endif
    @(negedge clk);
    or1 = 1;
    chk("sb1_depth", sb1.size(), 1);
    if (sb1.size() > 0) chk("sb1_msg", mo1, sb1.pop_front());
    @(posedge clk);
    #1 or1 = 0;
    chk("ir1_after", ir1, 1);
  endtask

  initial begin
    vec_t m, k;
    do_reset();
    @(negedge clk);
    chk("rst_ov0", ov0, 0);
    chk("rst_mo0", mo0, 0);
    chk("rst_ir0", ir0, 1);
    chk("rst_ov1", ov1, 0);
    chk("rst_ir1", ir1, 1);
`ifdef AONT_LEADER_OUT_EN
    chk("rst_lo0", lo0, 0);
`endif

    chk("gmul_15_15", gmul(8'd15, 8'd15, 4), 0);
    chk("gmul_0_0", gmul(8'd0, 8'd0, 4), 0);
    chk("gmul_1_1", gmul(8'd1, 8'd1, 4), 3);
    chk("gmul_15_0", gmul(8'd15, 8'd0, 4), 15);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) load0(a, b, (a + b) % 16);

    run0('0, '0, 0);
    for (int j = 0; j < 16; j++) begin
      chk("blk0", mo0[j*4 +: 4], 0);
      chk("blk1", mo0[(16+j)*4 +: 4], j);
      chk("blk2", mo0[(32+j)*4 +: 4], (2*j) % 16);
    end
    chk("tag0", mo0[(8*16)*4 +: 4], 0);
    fin0(0);

    run0(rnd(), rnd(), 0);
    fin0(20);

    run0(rnd(), rnd(), 1);
    fin0(2);

    // abort in the middle of BODY
    @(negedge clk);
    mi0 = MI0'(rnd());
    ki0 = K0'(rnd());
    iv0 = 1;
    @(posedge clk);
    #1 iv0 = 0;
    repeat (15 + 40) @(posedge clk);
    #1 rstn = 1'b1;
    foreach (tbl0[i]) tbl0[i] = 0;
    foreach (tbl1[i]) tbl1[i] = 0;
    #1;
    chk("abort_ov0", ov0, 0);
    chk("abort_mo0", mo0, 0);
`ifdef AONT_LEADER_OUT_EN
    chk("abort_lo0", lo0, 0);
`endif
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("abort_ir0", ir0, 1);
    run0(rnd(), rnd(), 0);
    fin0(0);

    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 256; b++) load1(a, b, b);
    m = rnd();
    run1(m, '0);
    m = rnd();
    k = rnd();
    run1(m, k);
    m = rnd();
    @(negedge clk);
    mi1 = m[MI1-1:0];
    ki1 = '0;
    iv1 = 1;
    @(posedge clk);
    #1 iv1 = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (ov1) break;
    end
    chk("id_blocks", mo1[MI1-1:0], m[MI1-1:0]);
    @(negedge clk);
    or1 = 1;
    @(posedge clk);
    #1 or1 = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aont_seq.md
# aont_seq

Sequential, parametrised all-or-nothing transform engine for the chaffing-and-winnowing datapath. It accepts one message plus key over a valid/ready handshake and walks leader, block and tag generation one symbol per cycle using a host-loaded Latin-square table. It then presents NBLK transformed blocks plus one tag block on a held valid/ready output. It replaces the single-cycle combinational transform, trading latency for area, and sits between the message framer and the chaff inserter.

## Interface
- W, 4, symbol width in bits; legal values 1, 2, 4, 8; Q = 2^W
- BLKSYMS, 16, symbols per block and key length
- NBLK, 8, message blocks per transform
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-high (asserted = 1)
- ls_we  in  1  table write strobe
- ls_addr  in  2W  table address, a*Q+b
- ls_data  in  W  table entry L(a,b)
- in_valid / in_ready  in / out  1  message handshake
- msg_i  in  NBLK*BLKSYMS*W  block i, symbol j at bits [(i*BLKSYMS+j)*W +: W]
- key_i  in  BLKSYMS*W  key symbol j at [j*W +: W]
- out_valid / out_ready  out / in  1  result handshake
- msg_o  out  (NBLK+1)*BLKSYMS*W  blocks 0..NBLK-1 then tag block, same packing

## Operation
- Group multiply: g(x,y) = (((x+1)*(y+1)) mod (Q+1)) - 1. Product width is 2W+2. The result is always in [0,Q-1].
- Leader: ld0 = k0; ldj = L(kj, ldj-1) for j=1..BLKSYMS-1. Seed s = ld(BLKSYMS-1).
- Block i, symbol j:
  - e(i,0) = L(s,0); e(i,j) = L(e(i,j-1), i mod Q).
  - b(i,j) = L(e(i,j), m(i,j)).
  - acc_j = b(0,j) for i=0; otherwise acc_j = g(acc_j, b(i,j)).
- Tag: t_j = g(acc_j, k_j). msg_o = {t, b(NBLK-1), ..., b(0)}.
- States and transitions:
  - IDLE: in_ready=1. On in_valid, capture msg_i and key_i, set ld=k0 -> LEADER.
  - LEADER: BLKSYMS-1 cycles, one leader step per cycle -> BODY.
  - BODY: NBLK*BLKSYMS cycles, one (i,j) step per cycle, j inner -> TAG.
  - TAG: BLKSYMS cycles -> OUT.
  - OUT: out_valid=1 and msg_o held stable. On out_ready -> IDLE.
- Table writes:
  - Accepted only in IDLE; ignored in every other state.
  - If ls_we and in_valid occur on the same IDLE edge, the write commits on that edge and the transform uses the new entry.
- Table contents are trusted. No Latin-property check is performed; a non-Latin table still yields the deterministic result of the formulas above.

## Timing
- Reset values: state IDLE, in_ready=1 (combinational from IDLE), out_valid=0, msg_o=0, all table entries 0, acc=0.
- Latency: out_valid rises (NBLK+2)*BLKSYMS-1 cycles after the accepting edge. Defaults give 159 cycles.
- Throughput: one transform per (NBLK+2)*BLKSYMS cycles plus the output handshake cycle. in_ready rises the cycle after the out handshake.
- Back-pressure: out_valid stays high and msg_o stays unchanged until out_ready=1. No new input is accepted meanwhile.
- Both table read ports are combinational from the registered table. Every step completes in a single cycle.
- Reset mid-operation aborts immediately:
  - All outputs and the table return to their reset values.
  - A partially computed result is never presented.
- Block index i wraps mod Q in the e-chain (matters when NBLK > Q).

## Configuration
- AONT_LEADER_OUT_EN defined:
  - Adds output port leader_o (W bits), which holds seed s from the end of LEADER until the next accept.
  - Reset value of leader_o is 0.
- AONT_LEADER_OUT_EN undefined: port and register are absent; all other behaviour is identical.

## Structure
- Package aont_pkg holds:
  - sym_t typedef;
  - state enum {IDLE, LEADER, BODY, TAG, OUT};
  - function gmul implementing g for a given W;
  - localparams Q and the msg_i, msg_o and key_i widths derived from W, BLKSYMS and NBLK.
- One sub-module, aont_ls_table: Q*Q x W register file with async reset, one write port and two combinational read ports.

## Test plan
- Reset, then idle -> out_valid=0, msg_o=0, in_ready=1. With AONT_LEADER_OUT_EN defined, leader_o=0.
- Defaults; table loaded with L(a,b)=(a+b) mod 16; key=0; msg=0 -> out_valid at edge 159 after accept:
  - block 0 all 0;
  - block 1 symbol j = j;
  - block 2 symbol j = 2j mod 16;
  - tag symbol 0 = 0.
- gmul unit check for W=4:
  - g(15,15) = 0;
  - g(0,0) = 0;
  - g(1,1) = 3;
  - g(15,0) = 15.
- Back-pressure: out_ready held 0 for 20 cycles after out_valid -> msg_o stable, in_ready=0, ls_we writes ignored. A later result uses the unchanged table.
- Reset asserted in BODY cycle 40 -> out_valid=0 and msg_o=0 immediately, table zeroed. After release, in_ready=1.
- W=8, NBLK=2, BLKSYMS=4 -> out_valid 15 cycles after accept. Identity-row table with key=0 returns msg_o blocks equal to L applied per the formulas.
